elixirchip_es1_spu_op_delay: RTL and testbench
==============================================

// Module: elixirchip_es1_spu_op_delay
//
// PURPOSE
// - Operand-alignment stage directly upstream of the SPU shift op: delays s_data, s_valid and s_clear
//   by LATENCY cycles so that data and shift amount reach the shift op in the same cycle.
// - Uses the same valid/clear/hold semantics as the SPU ops: data advances only when valid or clear;
//   clear forces CLEAR_DATA.
// - m_valid and m_clear drive the shift op's s_valid and s_clear directly.
//
// PARAMETERS
// - LATENCY         1                     number of register stages (0 = combinational pass-through)
// - DATA_BITS       8                     data width
// - data_t          logic[DATA_BITS-1:0]  data type
// - CLEAR_DATA      '0                    value loaded by a clear
// - RESET_DATA      '0                    value of every data register during reset
// - IMMEDIATE_DATA  1'b0                  1: s_data is constant; data is not registered, only valid/clear are delayed
// - DEVICE          "RTL"                 target device name
// - SIMULATION      "false"               simulation switch
// - DEBUG           "false"               debug switch
//
// PORTS
// - reset    in   1          asynchronous reset, active-high
// - clk      in   1          clock, the only clock
// - cke      in   1          clock enable; 0 freezes all state
// - s_data   in   data_t     input data
// - s_clear  in   1          clear request
// - s_valid  in   1          input data valid
// - m_data   out  data_t     delayed data
// - m_clear  out  1          delayed clear
// - m_valid  out  1          delayed valid
//
// BEHAVIOUR
// - Reset:
//   - Reset is asynchronous and active-high.
//   - While reset is high: every stage valid=0, clear=0, data=RESET_DATA.
//   - Outputs settle without a clock edge: m_valid=0, m_clear=0, m_data=RESET_DATA (LATENCY>0).
// - LATENCY=0: m_data=s_data, m_valid=s_valid, m_clear=s_clear, purely combinational; reset and cke are ignored.
// - Stages: stage k (k=1..LATENCY) has inputs (d,v,c) from stage k-1; stage 0 is the s_* ports.
// - Stage update, on posedge clk with cke=1 and reset=0:
//   - v_k <= v_{k-1}
//   - c_k <= c_{k-1}
//   - if c_{k-1}: d_k <= CLEAR_DATA
//   - else if v_{k-1}: d_k <= d_{k-1}
//   - else: d_k holds
// - Simultaneous s_clear and s_valid: clear wins for data; both flags propagate unchanged.
// - Outputs: m_* = stage LATENCY. Latency is exactly LATENCY cke-enabled cycles.
// - cke=0: no stage changes, including valid and clear; bubbles are not squeezed out.
// - Hold rule: m_data changes only in a cycle where m_valid or m_clear changed it, i.e. the stage
//   LATENCY-1 flags were 1 at that edge.
// - IMMEDIATE_DATA=1: m_data=s_data at all times (no data registers); v/c pipeline unchanged.
// - Reset asserted mid-stream: in-flight valids and clears are discarded; after release the first
//   m_valid is exactly LATENCY enabled cycles after the first post-reset s_valid.
// - There is no back-pressure; the block accepts one item every enabled cycle.
//
// STRUCTURE
// - No shared package is needed; data_t is a parameter type, as for the other SPU ops.
// - One sub-module: elixirchip_es1_spu_op_delay_stage, a single (d,v,c) register with async reset
//   and the update rule above, plus an IMMEDIATE_DATA bypass.
// - The top level is a generate-for chain of LATENCY stages, plus a LATENCY=0 assign branch.
//
// TESTING
// - LATENCY=3, DATA_BITS=8, cke=1: s_data=0x11,0x22,0x33 on valid in consecutive cycles
//   -> m_data/m_valid show 0x11,0x22,0x33 exactly 3 cycles later.
// - Gaps: valid 0x5A, then 2 idle cycles -> m_data stays 0x5A through the idle slots with m_valid=0.
// - Clear: s_clear=1 and s_valid=1 together with s_data=0x7F, CLEAR_DATA=0xA5
//   -> after 3 cycles m_data=0xA5, m_clear=1, m_valid=1.
// - cke toggling: cke=1010..., 4 valid items -> output order and values preserved;
//   the counted latency is 3 enabled edges.
// - Async reset: assert reset between clock edges while 2 items are in flight
//   -> m_valid=0 and m_data=RESET_DATA immediately; after release there is no stale output.
// - LATENCY=0 pass-through and IMMEDIATE_DATA=1 (s_data=0x3C constant)
//   -> m_data=0x3C at all times; m_valid delayed correctly.
// - All scenarios chain into the SPU shift op and check it with its existing assertions.

Source files
------------

// File: rtl/elixirchip_es1_spu_op_delay_stage.sv
// One (data, valid, clear) register of the SPU operand delay line.
// Data loads only on valid or clear, otherwise it holds; IMMEDIATE_DATA skips the data register.
module elixirchip_es1_spu_op_delay_stage #(
   parameter type  data_t         = logic [7:0],
   parameter data_t CLEAR_DATA    = '0,
   parameter data_t RESET_DATA    = '0,
   parameter logic IMMEDIATE_DATA = 1'b0
) (
   input  logic  reset,
   input  logic  clk,
   input  logic  cke,
   input  data_t s_data,
   input  logic  s_clear,
   input  logic  s_valid,
   output data_t m_data,
   output logic  m_clear,
   output logic  m_valid
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_clear <= 1'b0;
      end else if (cke) begin
         m_valid <= s_valid;
         m_clear <= s_clear;
      end
   end

   generate
      if (IMMEDIATE_DATA) begin : g_immediate
         // Constant operand: nothing to align, only the flags need delaying.
         assign m_data = s_data;
      end else begin : g_registered
         data_t data_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               data_q <= RESET_DATA;
            end else if (cke) begin
               if (s_clear) begin
                  data_q <= CLEAR_DATA;
               end else if (s_valid) begin
                  data_q <= s_data;
               end
            end
         end

         assign m_data = data_q;
      end
   endgenerate

endmodule

// File: rtl/elixirchip_es1_spu_op_delay.sv
// Operand-alignment delay line feeding the SPU shift op: LATENCY stages of (data, valid, clear).
// LATENCY=0 is a pure combinational pass-through.
module elixirchip_es1_spu_op_delay #(
   parameter int   LATENCY        = 1,
   parameter int   DATA_BITS      = 8,
   parameter type  data_t         = logic [DATA_BITS-1:0],
   parameter data_t CLEAR_DATA    = '0,
   parameter data_t RESET_DATA    = '0,
   parameter logic IMMEDIATE_DATA = 1'b0,
   parameter       DEVICE         = "RTL",
   parameter       SIMULATION     = "false",
   parameter       DEBUG          = "false"
) (
   input  logic  reset,
   input  logic  clk,
   input  logic  cke,
   input  data_t s_data,
   input  logic  s_clear,
   input  logic  s_valid,
   output data_t m_data,
   output logic  m_clear,
   output logic  m_valid
);

   generate
      if (LATENCY == 0) begin : g_bypass
         assign m_data  = s_data;
         assign m_clear = s_clear;
         assign m_valid = s_valid;
      end else begin : g_chain
         data_t stg_data  [0:LATENCY];
         logic  stg_clear [0:LATENCY];
         logic  stg_valid [0:LATENCY];

         assign stg_data[0]  = s_data;
         assign stg_clear[0] = s_clear;
         assign stg_valid[0] = s_valid;

         for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
            elixirchip_es1_spu_op_delay_stage #(
               .data_t         (data_t),
               .CLEAR_DATA     (CLEAR_DATA),
               .RESET_DATA     (RESET_DATA),
               .IMMEDIATE_DATA (IMMEDIATE_DATA)
            ) u_stage (
               .reset   (reset),
               .clk     (clk),
               .cke     (cke),
               .s_data  (stg_data[k-1]),
               .s_clear (stg_clear[k-1]),
               .s_valid (stg_valid[k-1]),
               .m_data  (stg_data[k]),
               .m_clear (stg_clear[k]),
               .m_valid (stg_valid[k])
            );
         end

         assign m_data  = stg_data[LATENCY];
         assign m_clear = stg_clear[LATENCY];
         assign m_valid = stg_valid[LATENCY];
      end
   endgenerate

   // The shift op consumes these flags directly, so an unknown here is always a bug upstream.
   generate
      if (DEVICE != "" && (SIMULATION == "true" || DEBUG == "true")) begin : g_sim_check
         always_ff @(posedge clk) begin
            if (!reset && cke) begin
               assert (!$isunknown({m_valid, m_clear}));
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_op_delay.sv
// Bench for the SPU operand delay line: directed table, corner sequences, random traffic vs a queue model.
module tb_elixirchip_es1_spu_op_delay;

   localparam int         L   = 3;
   localparam logic [7:0] CLR = 8'hA5;
   localparam logic [7:0] RST = 8'hE1;

   logic       clk = 1'b0;
   logic       reset;
   logic       cke;
   logic [7:0] s_data;
   logic       s_clear;
   logic       s_valid;
   logic [7:0] m_data, i_data, p_data;
   logic       m_clear, m_valid, i_clear, i_valid, p_clear, p_valid;

   always #5 clk = ~clk;

   elixirchip_es1_spu_op_delay #(
      .LATENCY(L), .DATA_BITS(8), .CLEAR_DATA(CLR), .RESET_DATA(RST),
      .IMMEDIATE_DATA(1'b0), .SIMULATION("true")
   ) u_dut (
      .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_clear(s_clear),
      .s_valid(s_valid), .m_data(m_data), .m_clear(m_clear), .m_valid(m_valid)
   );

   elixirchip_es1_spu_op_delay #(
      .LATENCY(L), .DATA_BITS(8), .CLEAR_DATA(CLR), .RESET_DATA(RST),
      .IMMEDIATE_DATA(1'b1)
   ) u_imm (
      .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_clear(s_clear),
      .s_valid(s_valid), .m_data(i_data), .m_clear(i_clear), .m_valid(i_valid)
   );

   elixirchip_es1_spu_op_delay #(
      .LATENCY(0), .DATA_BITS(8), .CLEAR_DATA(CLR), .RESET_DATA(RST)
   ) u_pass (
      .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_clear(s_clear),
      .s_valid(s_valid), .m_data(p_data), .m_clear(p_clear), .m_valid(p_valid)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: a FIFO of accepted items L-1 deep plus the last data the output took.
   typedef struct packed {
      logic       v;
      logic       c;
      logic [7:0] d;
   } item_t;

   item_t      pipe_q[$];
   item_t      mdl_out;
   logic [7:0] mdl_data;

   typedef struct {
      logic       v;
      logic       c;
      logic [7:0] d;
      logic       ev;
      logic       ec;
      logic [7:0] ed;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h required=%02h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void mdl_reset();
      pipe_q.delete();
      for (int i = 0; i < L - 1; i++) pipe_q.push_back('0);
      mdl_out  = '0;
      mdl_data = RST;
   endfunction

   function automatic void mdl_edge();
      item_t in_item;
      if (reset) begin
         mdl_reset();
      end else if (cke) begin
         in_item = '{v: s_valid, c: s_clear, d: s_data};
         pipe_q.push_back(in_item);
         mdl_out = pipe_q.pop_front();
         if (mdl_out.c)      mdl_data = CLR;
         else if (mdl_out.v) mdl_data = mdl_out.d;
      end
   endfunction

   task automatic check_all();
      chk("main_valid", {7'd0, m_valid}, {7'd0, mdl_out.v});
      chk("main_clear", {7'd0, m_clear}, {7'd0, mdl_out.c});
      chk("main_data",  m_data, mdl_data);
      chk("imm_valid",  {7'd0, i_valid}, {7'd0, mdl_out.v});
      chk("imm_clear",  {7'd0, i_clear}, {7'd0, mdl_out.c});
      chk("imm_data",   i_data, s_data);
      chk("pass_valid", {7'd0, p_valid}, {7'd0, s_valid});
      chk("pass_clear", {7'd0, p_clear}, {7'd0, s_clear});
      chk("pass_data",  p_data, s_data);
   endtask

   task automatic tick();
      @(posedge clk);
      mdl_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input logic v, input logic c, input logic [7:0] d, input logic k);
      s_valid = v;
      s_clear = c;
      s_data  = d;
      cke     = k;
   endtask

   initial begin
      int lat;

      vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, RST};
      vecs[1]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, RST};
      vecs[2]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 8'h11};
      vecs[3]  = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h22};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33};
      vecs[5]  = '{1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 8'h5A};
      vecs[6]  = '{1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 8'h5A};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A};
      vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, CLR};
      vecs[9]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, CLR};
      vecs[10] = '{1'b1, 1'b0, 8'h66, 1'b0, 1'b0, CLR};
      vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, CLR};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h66};
      vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h66};

      reset = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      mdl_reset();
      #1;
      chk("reset_valid", {7'd0, m_valid}, 8'd0);
      chk("reset_data",  m_data, RST);
      repeat (3) tick();
      reset = 1'b0;

      // Directed stream: back-to-back items, idle gap, clear+valid together, clear alone.
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].v, vecs[i].c, vecs[i].d, 1'b1);
         tick();
         chk($sformatf("vec%0d_valid", i), {7'd0, m_valid}, {7'd0, vecs[i].ev});
         chk($sformatf("vec%0d_clear", i), {7'd0, m_clear}, {7'd0, vecs[i].ec});
         chk($sformatf("vec%0d_data", i),  m_data, vecs[i].ed);
      end

      // cke toggling 1010...: four items, latency counted in enabled edges only.
      for (int i = 0; i < 16; i++) begin
         if (i < 8) drive((i % 2) == 0, 1'b0, 8'(8'h11 * (i / 2 + 1)), (i % 2) == 0);
         else       drive(1'b0, 1'b0, 8'h00, (i % 2) == 0);
         tick();
      end

      // Async reset between edges with two items in flight.
      drive(1'b1, 1'b0, 8'hC1, 1'b1);
      tick();
      drive(1'b1, 1'b0, 8'hC2, 1'b1);
      tick();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      mdl_reset();
      chk("async_rst_valid", {7'd0, m_valid}, 8'd0);
      chk("async_rst_clear", {7'd0, m_clear}, 8'd0);
      chk("async_rst_data",  m_data, RST);
      chk("async_rst_imm_valid", {7'd0, i_valid}, 8'd0);
      check_all();
      repeat (2) tick();
      #2;
      reset = 1'b0;
      repeat (4) tick();

      drive(1'b1, 1'b0, 8'h5C, 1'b1);
      tick();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      lat = 1;
      while (!(m_valid === 1'b1 && m_data === 8'h5C) && lat < 10) begin
         tick();
         lat++;
      end
      chk("post_reset_latency", lat[7:0], 8'd3);

      // Constant operand: immediate instance must show it on every cycle.
      for (int i = 0; i < 20; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), 8'h3C, 1'b1);
         tick();
         chk("imm_const", i_data, 8'h3C);
      end

      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
